// File: rtl/pe_acc_drain.sv
// Captures the accumulator vector on a done pulse and requantizes every lane to DATA_WIDTH.
// Streams the result as BEATS valid/ready beats; done pulses that arrive while busy are dropped and flagged.
module pe_acc_drain #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int BEAT_COPIES = 8,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_acc_result,
    input  logic                              i_acc_done,
    output logic                              o_acc_clear,
    input  logic [SHIFT_WIDTH-1:0]            i_shift,
    input  logic                              i_relu,
    output logic                              o_busy,
    output logic [BEAT_COPIES*DATA_WIDTH-1:0] o_data,
    output logic                              o_data_vld,
    input  logic                              i_data_rdy,
    output logic                              o_last,
    output logic                              o_drop_err
);
    localparam int AW     = 2 * DATA_WIDTH;
    localparam int BEATS  = DATA_COPIES / BEAT_COPIES;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = BEAT_COPIES * DATA_WIDTH;
    localparam logic signed [AW:0] MAX_V = {{(AW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW:0] MIN_V = ~MAX_V;
    localparam logic signed [AW:0] ONE_V = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, QUANT, SEND} state_t;

    state_t                          state_q, state_d;
    logic [BW-1:0]                   beat_q, beat_d;
    logic [DATA_COPIES*AW-1:0]       cap_q, cap_d;
    logic [SHIFT_WIDTH-1:0]          shift_q, shift_d;
    logic                            relu_q, relu_d;
    logic                            drop_err_q, drop_err_d;
    logic [BEAT_W-1:0]               quant_q [BEATS];
    logic [BEAT_W-1:0]               quant_d [BEATS];

    // One extra bit of headroom so the rounding add never wraps before the shift.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic [AW-1:0] x,
                                                      input logic [SHIFT_WIDTH-1:0] s,
                                                      input logic relu);
        logic signed [AW:0] v;
        v = {x[AW-1], x};
        if (s != '0) v = (v + (ONE_V <<< (s - SHIFT_WIDTH'(1)))) >>> s;
        if (v > MAX_V)      v = MAX_V;
        else if (v < MIN_V) v = MIN_V;
        if (relu && v[AW])  v = '0;
        return v[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cap_d      = cap_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        quant_d    = quant_q;
        drop_err_d = drop_err_q | (i_acc_done & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (i_acc_done) begin
                    cap_d   = i_acc_result;
                    shift_d = i_shift;
                    relu_d  = i_relu;
                    state_d = QUANT;
                end
            end
            QUANT: begin
                for (int b = 0; b < BEATS; b++) begin
                    for (int j = 0; j < BEAT_COPIES; j++) begin
                        quant_d[b][j*DATA_WIDTH +: DATA_WIDTH] =
                            requant(cap_q[(b*BEAT_COPIES+j)*AW +: AW], shift_q, relu_q);
                    end
                end
                beat_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (i_data_rdy) begin
                    if (beat_q == BW'(BEATS-1)) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            cap_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            drop_err_q <= 1'b0;
            for (int b = 0; b < BEATS; b++) quant_q[b] <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cap_q      <= cap_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            drop_err_q <= drop_err_d;
            for (int b = 0; b < BEATS; b++) quant_q[b] <= quant_d[b];
        end
    end

    // Clear only when the vector is actually captured, so a dropped done never loses data.
    assign o_acc_clear = i_acc_done && (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);
    assign o_data_vld  = (state_q == SEND);
    assign o_last      = o_data_vld && (beat_q == BW'(BEATS-1));
    assign o_data      = o_data_vld ? quant_q[beat_q] : '0;
    assign o_drop_err  = drop_err_q;
endmodule

// File: tb/tb_pe_acc_drain.sv
// Directed bench for pe_acc_drain: expected beats come from a behavioural requantizer and are
// queued at capture, then popped and compared as the DUT hands them off.
module tb_pe_acc_drain;
    localparam int DW = 8, DC = 32, BC = 8, SW = 4, BEATS = DC / BC;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [DC*2*DW-1:0] i_acc_result;
    logic              i_acc_done;
    logic              o_acc_clear;
    logic [SW-1:0]     i_shift;
    logic              i_relu;
    logic              o_busy;
    logic [BC*DW-1:0]  o_data;
    logic              o_data_vld;
    logic              i_data_rdy;
    logic              o_last;
    logic              o_drop_err;

    pe_acc_drain #(.DATA_WIDTH(DW), .DATA_COPIES(DC), .BEAT_COPIES(BC), .SHIFT_WIDTH(SW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_acc_result(i_acc_result), .i_acc_done(i_acc_done),
        .o_acc_clear(o_acc_clear), .i_shift(i_shift), .i_relu(i_relu), .o_busy(o_busy),
        .o_data(o_data), .o_data_vld(o_data_vld), .i_data_rdy(i_data_rdy), .o_last(o_last),
        .o_drop_err(o_drop_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [BC*DW-1:0] dat; logic last; } beat_t;
    beat_t exp_q[$];
    int    lanes_v[DC];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Floor-division form of round-half-up, independent of shift operators.
    function automatic logic [DW-1:0] model(input int x, input int s, input bit relu);
        int y, d, q;
        if (s == 0) y = x;
        else begin
            d = 1 << s;
            q = x + d / 2;
            y = q / d;
            if ((q % d) != 0 && q < 0) y = y - 1;
        end
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        if (relu && y < 0) y = 0;
        return DW'(y);
    endfunction

    task automatic fill_rand();
        logic signed [15:0] t;
        for (int k = 0; k < DC; k++) begin
            t = 16'($urandom);
            lanes_v[k] = int'(t);
        end
    endtask

    task automatic send_vec(input int s, input bit r);
        beat_t e;
        logic signed [15:0] t;
        @(negedge i_clk);
        chk("idle_vld", 64'(o_data_vld), 64'd0);
        chk("idle_busy", 64'(o_busy), 64'd0);
        for (int k = 0; k < DC; k++) i_acc_result[k*16 +: 16] = 16'(lanes_v[k]);
        i_shift = SW'(s);
        i_relu = r;
        i_acc_done = 1'b1;
        #1 chk("done_clear", 64'(o_acc_clear), 64'd1);
        for (int b = 0; b < BEATS; b++) begin
            for (int j = 0; j < BC; j++) e.dat[j*DW +: DW] = model(lanes_v[b*BC+j], s, r);
            e.last = (b == BEATS - 1);
            exp_q.push_back(e);
        end
        @(negedge i_clk);
        i_acc_done = 1'b0;
        for (int k = 0; k < DC; k++) begin
            t = 16'($urandom);
            i_acc_result[k*16 +: 16] = t;
        end
        chk("quant_busy", 64'(o_busy), 64'd1);
        chk("quant_vld", 64'(o_data_vld), 64'd0);
    endtask

    // mode 0: ready always high; mode 1: 3-cycle stall on beat 1 then random ready.
    task automatic drain(input int mode, input logic [3:0] inj, input int stop_after);
        int got = 0, cyc = 0, stall_cnt = 0;
        logic pstall = 1'b0, pl = 1'b0;
        logic [BC*DW-1:0] pd = '0;
        beat_t e;
        while (got < stop_after && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
            i_acc_done = 1'b0;
            i_relu = 1'($urandom);
            i_shift = SW'($urandom);
            if (mode == 0) i_data_rdy = 1'b1;
            else if (got == 1 && stall_cnt < 3) begin
                i_data_rdy = 1'b0;
                stall_cnt++;
            end else i_data_rdy = 1'($urandom_range(0, 1));
            if (o_data_vld && i_data_rdy && inj[got]) i_acc_done = 1'b1;
            #1;
            if (i_acc_done) chk("drop_clear", 64'(o_acc_clear), 64'd0);
            if (mode == 0) chk("stream_vld", 64'(o_data_vld), 64'd1);
            chk("send_busy", 64'(o_busy), 64'd1);
            if (pstall) begin
                chk("stall_vld", 64'(o_data_vld), 64'd1);
                chk("stall_dat", 64'(o_data), 64'(pd));
                chk("stall_last", 64'(o_last), 64'(pl));
            end
            if (o_data_vld && i_data_rdy) begin
                chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat_dat", 64'(o_data), 64'(e.dat));
                    chk("beat_last", 64'(o_last), 64'(e.last));
                end
                got++;
            end
            pstall = o_data_vld && !i_data_rdy;
            pd = o_data;
            pl = o_last;
        end
        i_acc_done = 1'b0;
        chk("drain_count", 64'(got), 64'(stop_after));
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_acc_result = '0;
        i_acc_done = 1'b0;
        i_shift = '0;
        i_relu = 1'b0;
        i_data_rdy = 1'b0;
        #12;
        chk("rst_vld", 64'(o_data_vld), 64'd0);
        chk("rst_dat", 64'(o_data), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_drop", 64'(o_drop_err), 64'd0);
        chk("rst_clear", 64'(o_acc_clear), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Basic rounding, ready held high: beat 0 on T+2, back-to-back beats.
        for (int k = 0; k < DC; k++) lanes_v[k] = 16;
        lanes_v[0] = 56;
        lanes_v[1] = -24;
        send_vec(4, 1'b0);
        drain(0, 4'b0000, BEATS);

        // Saturation and rounding corners.
        fill_rand();
        lanes_v[0] = 32767;
        lanes_v[1] = -32768;
        send_vec(0, 1'b0);
        drain(1, 4'b0000, BEATS);
        fill_rand();
        lanes_v[0] = -8;
        send_vec(4, 1'b0);
        drain(0, 4'b0000, BEATS);
        fill_rand();
        lanes_v[0] = 3;
        lanes_v[9] = -3;
        send_vec(1, 1'b0);
        drain(1, 4'b0000, BEATS);

        // ReLU; drain toggles i_relu/i_shift every cycle.
        fill_rand();
        lanes_v[0] = -5;
        lanes_v[1] = 5;
        send_vec(0, 1'b1);
        drain(0, 4'b0000, BEATS);

        // Backpressure with mid-range shift.
        fill_rand();
        send_vec(7, 1'b0);
        drain(1, 4'b0000, BEATS);
        chk("no_drop_yet", 64'(o_drop_err), 64'd0);

        // Done during SEND and in the final-handshake cycle are dropped.
        fill_rand();
        send_vec(5, 1'b1);
        drain(0, 4'b1010, BEATS);
        chk("drop_err", 64'(o_drop_err), 64'd1);
        fill_rand();
        send_vec(3, 1'b0);
        drain(0, 4'b0000, BEATS);
        chk("drop_sticky", 64'(o_drop_err), 64'd1);

        // Reset while beat 2 is presented.
        fill_rand();
        send_vec(2, 1'b0);
        drain(1, 4'b0000, 2);
        @(negedge i_clk);
        i_data_rdy = 1'b0;
        #1 chk("pre_rst_vld", 64'(o_data_vld), 64'd1);
        i_rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(o_data_vld), 64'd0);
        chk("arst_dat", 64'(o_data), 64'd0);
        chk("arst_last", 64'(o_last), 64'd0);
        chk("arst_busy", 64'(o_busy), 64'd0);
        chk("arst_drop", 64'(o_drop_err), 64'd0);
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_data_rdy = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            chk("post_rst_vld", 64'(o_data_vld), 64'd0);
        end
        fill_rand();
        send_vec(4, 1'b1);
        drain(0, 4'b0000, BEATS);
        @(negedge i_clk);
        chk("end_vld", 64'(o_data_vld), 64'd0);
        chk("end_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
